// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue.
// Credits cover queued plus in-flight words, so a response always has a slot.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        jump_enable,
  input  logic [31:0] jump_address,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [31:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_req_fire;
  logic          w_rsp_acc;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_left;

  assign w_inflight = {1'b0, r_occ} + {1'b0, r_out};

  assign imem_req_valid = !reset && !jump_enable
                        && (w_inflight < LIM);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses with nothing in flight are spurious and ignored.
  assign w_rsp_acc  = imem_rsp_valid && (r_out != '0);
  assign w_push     = w_rsp_acc && (r_drop == '0)
                    && !jump_enable && !reset;
  assign w_out_left = r_out - CW'(w_rsp_acc);

  assign valid_out = (r_occ != '0) && !jump_enable && !reset;
  assign w_pop     = valid_out && !stall;

  assign instruction_out = valid_out ? r_ins_mem[r_rd] : NOP_INSTR;
  assign pc_out          = valid_out ? r_pc_mem[r_rd]  : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_occ      <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
    end else if (jump_enable) begin
      r_fetch_pc <= jump_address;
      r_resp_pc  <= jump_address;
      r_occ      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_out      <= w_out_left;
      // Everything still in flight belongs to the abandoned path.
      r_drop     <= w_out_left;
    end else begin
      if (w_req_fire)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      r_out <= r_out + CW'(w_req_fire) - CW'(w_rsp_acc);
      if (w_rsp_acc && (r_drop != '0))
        r_drop <= r_drop - CW'(1);
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr      <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr]  <= r_resp_pc;
      r_ins_mem[r_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: memory model plus in-order scoreboard.
// Each issued address is expected back as pc, with data addr ^ KEY.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        jump_enable;
  logic [31:0] jump_address;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        valid_out;

  fetch_prefetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .jump_enable    (jump_enable),
    .jump_address   (jump_address),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic [31:0] prev_addr;
  logic        prev_wait;
  int          cyc;
  int          lat;
  int          n_vec;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time expired, want summary");
    $fatal(1);
  end

  // Memory: in-order responses, lat cycles after acceptance.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].addr ^ KEY;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      mem_q.delete();
      exp_fetch = 32'h0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && !jump_enable) begin
        n_vec++;
        if (!imem_req_valid || imem_req_addr !== prev_addr) begin
          n_err++;
          $display("FAIL req_hold: valid %b addr %h, want 1 %h",
                   imem_req_valid, imem_req_addr, prev_addr);
        end
      end
      n_vec++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_empty: pc %h with nothing expected", pc_out);
        end else begin
          if (pc_out !== exp_q[0] ||
              instruction_out !== (exp_q[0] ^ KEY)) begin
            n_err++;
            $display("FAIL sb_out: pc %h instr %h, want %h %h",
                     pc_out, instruction_out, exp_q[0],
                     exp_q[0] ^ KEY);
          end
          if (!stall) void'(exp_q.pop_front());
        end
      end else if (instruction_out !== NOP || pc_out !== 32'h0) begin
        n_err++;
        $display("FAIL bubble: instr %h pc %h, want %h 0",
                 instruction_out, pc_out, NOP);
      end
      if (jump_enable) begin
        exp_q.delete();
        exp_fetch = jump_address;
      end else if (imem_req_valid && imem_req_ready) begin
        n_vec++;
        if (imem_req_addr !== exp_fetch) begin
          n_err++;
          $display("FAIL req_seq: addr %h, want %h",
                   imem_req_addr, exp_fetch);
        end
        mem_q.push_back('{imem_req_addr, cyc + lat});
        exp_q.push_back(imem_req_addr);
        exp_fetch = imem_req_addr + 32'd4;
      end
      prev_wait = imem_req_valid && !imem_req_ready && !jump_enable;
      prev_addr = imem_req_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset       = 1'b1;
    jump_enable = 1'b0;
    stall       = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req: valid %b, want 0", imem_req_valid);
    end
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid: valid %b, want 0", valid_out);
    end
    n_vec++;
    if (instruction_out !== NOP || pc_out !== 32'h0) begin
      n_err++;
      $display("FAIL rst_out: instr %h pc %h, want %h 0",
               instruction_out, pc_out, NOP);
    end
  endtask

  task automatic test_stream();
    int first;
    lat = 1;
    do_reset();
    first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_out) begin
        first = i;
        break;
      end
    end
    n_vec++;
    if (first < 0 || first > 3 || pc_out !== 32'h0) begin
      n_err++;
      $display("FAIL first_valid: cycle %0d pc %h, want <=3 0",
               first, pc_out);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_vec++;
      if (!valid_out || pc_out !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL stream: valid %b pc %h, want 1 %h",
                 valid_out, pc_out, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    logic        seen;
    logic [31:0] first_req;
    lat = 1;
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        n_vec++;
        if (!valid_out || pc_out !== 32'h0) begin
          n_err++;
          $display("FAIL stall_first: valid %b pc %h, want 1 0",
                   valid_out, pc_out);
        end
      end
      if (i == 9) begin
        n_vec++;
        if (imem_req_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stall_full: req_valid %b, want 0",
                   imem_req_valid);
        end
      end
    end
    tick();
    stall = 1'b0;
    seen = 1'b0;
    first_req = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (!valid_out || pc_out !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL stall_drain: valid %b pc %h, want 1 %h",
                 valid_out, pc_out, 32'(4 * i));
      end
      if (imem_req_valid && !seen) begin
        seen = 1'b1;
        first_req = imem_req_addr;
      end
    end
    n_vec++;
    if (!seen || first_req !== 32'h10) begin
      n_err++;
      $display("FAIL stall_resume: seen %b addr %h, want 1 00000010",
               seen, first_req);
    end
  endtask

  task automatic test_jump_stale();
    logic found;
    lat = 3;
    do_reset();
    tick();
    tick();
    jump_enable  = 1'b1;
    jump_address = 32'h100;
    @(negedge clk);
    n_vec++;
    if (valid_out || imem_req_valid || instruction_out !== NOP) begin
      n_err++;
      $display("FAIL jump_bubble: vo %b rq %b instr %h, want 0 0 %h",
               valid_out, imem_req_valid, instruction_out, NOP);
    end
    tick();
    jump_enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_out) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found || pc_out !== 32'h100 ||
        instruction_out !== (32'h100 ^ KEY)) begin
      n_err++;
      $display("FAIL jump_target: found %b pc %h instr %h, want 100",
               found, pc_out, instruction_out);
    end
  endtask

  task automatic test_back_to_back();
    logic found;
    lat = 3;
    do_reset();
    tick();
    tick();
    jump_enable  = 1'b1;
    jump_address = 32'h200;
    tick();
    jump_address = 32'h300;
    tick();
    jump_enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_out) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found || pc_out !== 32'h300) begin
      n_err++;
      $display("FAIL b2b_target: found %b pc %h, want 1 00000300",
               found, pc_out);
    end
  endtask

  task automatic test_jump_rsp();
    logic found;
    lat = 1;
    do_reset();
    stall = 1'b1;
    tick();
    tick();
    tick();
    stall        = 1'b0;
    jump_enable  = 1'b1;
    jump_address = 32'h400;
    @(negedge clk);
    n_vec++;
    if (valid_out !== 1'b0 || imem_rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL jrsp_mask: vo %b rsp %b, want 0 1",
               valid_out, imem_rsp_valid);
    end
    tick();
    jump_enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_out) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found || pc_out !== 32'h400 ||
        instruction_out !== (32'h400 ^ KEY)) begin
      n_err++;
      $display("FAIL jrsp_target: found %b pc %h instr %h, want 400",
               found, pc_out, instruction_out);
    end
  endtask

  task automatic test_ready_low();
    lat = 1;
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (!imem_req_valid || imem_req_addr !== 32'h0) begin
        n_err++;
        $display("FAIL rdy_hold: valid %b addr %h, want 1 0",
                 imem_req_valid, imem_req_addr);
      end
    end
    tick();
    imem_req_ready = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (!imem_req_valid || imem_req_addr !== 32'h4) begin
      n_err++;
      $display("FAIL rdy_adv: valid %b addr %h, want 1 4",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    lat = 1;
    do_reset();
    stall = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (valid_out || imem_req_valid || instruction_out !== NOP) begin
      n_err++;
      $display("FAIL mid_rst: vo %b rq %b instr %h, want 0 0 %h",
               valid_out, imem_req_valid, instruction_out, NOP);
    end
    tick();
    reset = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    n_vec++;
    if (valid_out || !imem_req_valid || imem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL mid_refetch: vo %b rq %b addr %h, want 0 1 0",
               valid_out, imem_req_valid, imem_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_out) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found || pc_out !== 32'h0) begin
      n_err++;
      $display("FAIL mid_first: found %b pc %h, want 1 0",
               found, pc_out);
    end
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    cyc            = 0;
    lat            = 1;
    exp_fetch      = 32'h0;
    prev_addr      = 32'h0;
    prev_wait      = 1'b0;
    reset          = 1'b1;
    stall          = 1'b0;
    jump_enable    = 1'b0;
    jump_address   = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_jump_stale();
    test_back_to_back();
    test_jump_rsp();
    test_ready_low();
    test_reset_mid();
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Front-end fetch block between instruction memory and the decode stage. It issues sequential instruction-memory requests over a valid/ready channel and buffers in-order responses in a DEPTH-entry prefetch queue. It presents {instruction, pc} to decode, honouring the decode stall and the execute-stage jump/discard redirect. When it has no valid instruction, it emits a NOP bubble, because the pipeline carries no per-stage valid bit.

Parameters:
DEPTH, 4, queue entries and maximum in-flight requests; power of two, >=2
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_req_valid  out  1  request address valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response data valid; responses return in request order
imem_rsp_data  in  32  returned instruction word
stall  in  1  decode cannot accept this cycle
jump_enable  in  1  redirect/discard from execute
jump_address  in  32  redirect target
instruction_out  out  32  instruction to decode
pc_out  out  32  address of instruction_out
valid_out  out  1  instruction_out is real, not a bubble

Behaviour:
- State:
  - fetch_pc: next request address.
  - resp_pc: pc of the next non-stale response.
  - occupancy count, 0..DEPTH.
  - outstanding count, 0..DEPTH, covering all in-flight requests.
  - drop count of stale in-flight responses.
  - Queue storage: DEPTH x {pc[31:0], instr[31:0]}, circular rd/wr pointers.
- Reset (synchronous):
  - fetch_pc = resp_pc = RESET_PC.
  - Queue empty; outstanding = drop = 0.
  - During and after the reset cycle: imem_req_valid = 0, valid_out = 0, instruction_out = NOP_INSTR, pc_out = 0.
- Request issue:
  - imem_req_valid = !reset && !jump_enable && (occupancy + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - Handshake at valid && ready: outstanding++, fetch_pc += 4 (32-bit wrap at 0xFFFF_FFFC -> 0).
  - Addr is stable while valid && !ready. Withdrawal is permitted only on a jump_enable cycle.
- Response accept (imem_rsp_valid, only when outstanding > 0):
  - outstanding--.
  - If drop > 0: drop--, data discarded.
  - Else push {resp_pc, imem_rsp_data}; resp_pc += 4.
  - rsp_valid while outstanding == 0 is ignored.
- Credit rule:
  - occupancy + outstanding <= DEPTH always, so a push never meets a full queue.
  - Push and pop in the same cycle leave occupancy unchanged.
- Output (combinational, first-word-fall-through):
  - valid_out = (occupancy != 0) && !jump_enable && !reset.
  - instruction_out/pc_out = head entry when valid_out; otherwise NOP_INSTR/0.
  - Pop when valid_out && !stall.
  - stall with empty queue: no effect.
- Latency: response accepted in cycle N is at the output in cycle N+1, at minimum.
- Redirect (jump_enable = 1):
  - Output masked to bubble that cycle.
  - At the edge: queue flushed, fetch_pc = resp_pc = jump_address, drop = outstanding - (accepted rsp this cycle ? 1 : 0).
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle; the first request at the target issues the next cycle.
  - Back-to-back redirects: the later target wins; drop recomputes from the current outstanding.
- Reset wins over redirect, push and pop. Instruction memory is reset in the same cycle; in-flight responses are not expected after reset.

Test Plan:
1. Reset, ready = 1, memory latency 1, data = addr ^ 32'hA5A5_0000 -> first valid_out by cycle 3 with pc 0; then pc 0,4,8,12… one per cycle with matching data; imem_req_addr never skips.
2. stall = 1 for 8 cycles after the first valid -> occupancy reaches 4, imem_req_valid falls to 0, no entry overwritten; release -> pcs 0,4,8,12 out in order on consecutive cycles, fetch resumes at 16.
3. Memory latency 3, jump_enable pulse with target 0x100 while 2 requests are outstanding -> the 2 stale responses are discarded; next valid_out has pc 0x100; bubble (NOP, valid 0) in the redirect cycle.
4. jump_enable coincident with imem_rsp_valid and a non-empty queue -> response and queue dropped, drop = outstanding - 1, first output pc = target.
5. imem_req_ready = 0 for 3 cycles -> imem_req_valid held, imem_req_addr constant, fetch_pc advances by exactly 4 on acceptance.
6. reset asserted mid-stream (queue 3 full, 1 outstanding) -> next cycle valid_out = 0, instruction_out = NOP_INSTR, outstanding = 0; refetch starts at RESET_PC.
